// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit with HI/LO registers.
// One product or quotient bit is produced per clock. MTHI/MTLO write the
// result registers directly in a single cycle.
//
// Ports:
//   clk      - clock, rising-edge
//   reset_n  - asynchronous active-low reset
//   start    - request, sampled only while idle
//   op       - 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
//   A, B     - operands (B ignored for MTHI/MTLO)
//   busy     - iterative op in progress
//   done     - one-cycle pulse, hi/lo hold the new result
//   divzero  - last DIVU had a zero divisor; held until the next accepted start
//   hi, lo   - HI/LO result registers
module muldiv_unit #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         divzero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t         state, state_nx;
  logic [2*N-1:0] acc;   // multiply: {partial product, remaining multiplier bits}
  logic [N-1:0]   opa;   // multiplicand, or dividend shifting out / quotient shifting in
  logic [N-1:0]   opb;   // divisor
  logic [N-1:0]   rem;   // partial remainder
  logic [CW-1:0]  cnt;

  // Shift-add step; the sum keeps its carry in bit N so nothing is lost
  // before the right shift.
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_nx;
  assign mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opa} : '0);
  assign mul_nx  = {mul_sum, acc[N-1:1]};

  // Restoring-divide step. With a zero divisor every trial succeeds, which
  // yields an all-ones quotient and a remainder equal to the dividend.
  logic [N:0]   rem_sh, diff;
  logic         qbit;
  logic [N-1:0] rem_nx, quo_nx;
  assign rem_sh = {rem, opa[N-1]};
  assign diff   = rem_sh - {1'b0, opb};
  assign qbit   = ~diff[N];
  assign rem_nx = qbit ? diff[N-1:0] : rem_sh[N-1:0];
  assign quo_nx = {opa[N-2:0], qbit};

  logic last;
  assign last = (cnt == CW'(1));

  assign busy = (state == MUL) || (state == DIV);
  assign done = (state == FIN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = op[1] ? FIN : (op[0] ? DIV : MUL);
      MUL,
      DIV:  if (last) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      rem     <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      divzero <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          divzero <= 1'b0;
          case (op)
            2'b00: begin
              opa <= A;
              acc <= {{N{1'b0}}, B};
              cnt <= CW'(N);
            end
            2'b01: begin
              opa <= A;
              opb <= B;
              rem <= '0;
              cnt <= CW'(N);
            end
            2'b10: hi <= A;
            2'b11: lo <= A;
            default: ;
          endcase
        end
        MUL: begin
          acc <= mul_nx;
          cnt <= cnt - CW'(1);
          if (last) {hi, lo} <= mul_nx;
        end
        DIV: begin
          opa <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt - CW'(1);
          if (last) begin
            lo      <= quo_nx;
            hi      <= rem_nx;
            divzero <= (opb == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized
// ops compared against plain-arithmetic expectations.
module tb_muldiv_unit;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] A = '0, B = '0;
  logic         busy, done, divzero;
  logic [N-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // model of architectural state
  logic [N-1:0] mhi = '0, mlo = '0;
  logic         mdz = 1'b0;

  muldiv_unit #(.N(N), .CW(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: results from plain arithmetic.
  task automatic model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    case (o)
      2'b00: begin p = 64'(a) * 64'(b); mhi = p[2*N-1:N]; mlo = p[N-1:0]; mdz = 1'b0; end
      2'b01: begin
        if (b == 0) begin mlo = '1; mhi = a; mdz = 1'b1; end
        else begin mlo = a / b; mhi = a % b; mdz = 1'b0; end
      end
      2'b10: begin mhi = a; mdz = 1'b0; end
      default: begin mlo = a; mdz = 1'b0; end
    endcase
  endtask

  // Issue one op and observe until done (bounded). Cycle 1 is the cycle right
  // after the start edge. done_at = -1 on timeout. hold_bad counts cycles
  // before done where hi/lo differed from their pre-op values.
  task automatic do_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       output int busy_cnt, output int done_at, output int hold_bad);
    logic [N-1:0] phi, plo;
    @(negedge clk);
    phi = hi; plo = lo;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom);
    busy_cnt = 0; done_at = -1; hold_bad = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_at = cyc; break; end
      if (hi !== phi || lo !== plo) hold_bad++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, divzero} !== 3'b000 || hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, want all 0", busy, done, divzero, hi, lo);
    end
    @(negedge clk); reset_n = 1'b1;
    mhi = '0; mlo = '0; mdz = 1'b0;
  endtask

  task automatic test_mul_max;
    int bc, da, hb;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, da, hb);
    model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (bc !== 32 || da !== 33) begin
      errors++; $display("FAIL mul_max_timing: busy=%0d done_at=%0d, want 32/33", bc, da);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++; $display("FAIL mul_max_result: hi=%h lo=%h, want fffffffe/00000001", hi, lo);
    end
    checks++;
    if (hb !== 0) begin
      errors++; $display("FAIL mul_hold: %0d cycles with partial hi/lo, want 0", hb);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_width: done=%b one cycle after pulse, want 0", done);
    end
  endtask

  task automatic test_div;
    int bc, da, hb;
    do_op(2'b01, 32'd100, 32'd7, bc, da, hb);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || divzero !== 1'b0 || da !== 33) begin
      errors++; $display("FAIL div_100_7: lo=%0d hi=%0d dz=%b done_at=%0d, want 14/2/0/33", lo, hi, divzero, da);
    end
  endtask

  task automatic test_divzero;
    int bc, da, hb;
    do_op(2'b01, 32'h1234_5678, 32'd0, bc, da, hb);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678 || divzero !== 1'b1 || da !== 33) begin
      errors++; $display("FAIL div_zero: lo=%h hi=%h dz=%b done_at=%0d, want ffffffff/12345678/1/33", lo, hi, divzero, da);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (divzero !== 1'b1) begin
      errors++; $display("FAIL divzero_hold: dz=%b after idle cycles, want 1", divzero);
    end
    do_op(2'b11, 32'h0000_0055, 32'd0, bc, da, hb);
    checks++;
    if (divzero !== 1'b0 || lo !== 32'h55 || hi !== 32'h1234_5678) begin
      errors++; $display("FAIL divzero_clear: dz=%b lo=%h hi=%h, want 0/55/12345678", divzero, lo, hi);
    end
  endtask

  task automatic test_moves;
    int bc, da, hb, bc2, da2;
    do_op(2'b10, 32'hDEAD_BEEF, 32'h1, bc, da, hb);
    do_op(2'b11, 32'hCAFE_F00D, 32'h2, bc2, da2, hb);
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL moves_result: hi=%h lo=%h, want deadbeef/cafef00d", hi, lo);
    end
    checks++;
    if (bc !== 0 || bc2 !== 0 || da !== 1 || da2 !== 1) begin
      errors++; $display("FAIL moves_timing: busy=%0d/%0d done_at=%0d/%0d, want 0/0 1/1", bc, bc2, da, da2);
    end
  endtask

  task automatic test_restart_ignored;
    int dcnt, da;
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0; da = -1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (done) begin dcnt++; da = cyc; end
      if (cyc == 5) begin start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd9; end
      if (cyc == 6) start = 1'b0;
      if (cyc > 6 && cyc < 30) begin A = $urandom; B = $urandom; end
    end
    checks++;
    if (dcnt !== 1 || da !== 33 || hi !== 32'd0 || lo !== 32'd15) begin
      errors++; $display("FAIL restart_ignored: dones=%0d done_at=%0d hi=%0d lo=%0d, want 1/33/0/15", dcnt, da, hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int bc, da, hb, dcnt;
    do_op(2'b10, 32'hA5A5_0001, 32'd0, bc, da, hb);
    @(negedge clk);
    start = 1'b1; op = 2'b01; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: busy=%b before reset, want 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, divzero} !== 3'b000 || hi !== 0 || lo !== 0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b dz=%b hi=%h lo=%h, want all 0", busy, done, divzero, hi, lo);
    end
    #2 reset_n = 1'b1;
    dcnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt !== 0 || hi !== 0 || lo !== 0) begin
      errors++; $display("FAIL reset_abort: active_cycles=%0d hi=%h lo=%h, want 0/0/0", dcnt, hi, lo);
    end
    do_op(2'b00, 32'd6, 32'd7, bc, da, hb);
    checks++;
    if (lo !== 32'd42 || hi !== 32'd0 || da !== 33) begin
      errors++; $display("FAIL mul_after_reset: lo=%0d hi=%0d done_at=%0d, want 42/0/33", lo, hi, da);
    end
    mhi = hi === 32'd0 ? 32'd0 : mhi; // model resync not needed; set below
    mhi = '0; mlo = 32'd42; mdz = 1'b0;
  endtask

  task automatic test_random;
    int bc, da, hb;
    logic [1:0]   o;
    logic [N-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = N'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      do_op(o, a, b, bc, da, hb);
      model(o, a, b);
      checks++;
      if (hi !== mhi || lo !== mlo || divzero !== mdz) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h dz=%b, want %h/%h/%b",
                 i, o, a, b, hi, lo, divzero, mhi, mlo, mdz);
      end
      checks++;
      if (bc !== (o[1] ? 0 : N) || da !== (o[1] ? 1 : N + 1) || hb !== 0) begin
        errors++;
        $display("FAIL random_timing_%0d op=%0d: busy=%0d done_at=%0d hold_bad=%0d", i, o, bc, da, hb);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mul_max;
    test_div;
    test_divzero;
    test_moves;
    test_restart_ignored;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
